i2c_slave_responder: RTL and testbench

I2C_SLAVE_RESPONDER -- requirements
Module: i2c_slave_responder

---
 rtl/i2c_slave_pkg.sv | 24 ++
 rtl/i2c_bus_cond_det.sv | 74 +++++++
 rtl/i2c_slave_responder.sv | 187 ++++++++++++++++++
 tb/tb_i2c_slave_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave register responder.
package i2c_slave_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned BYTE_W = 8;

    typedef logic [ADDR_W-1:0] i2c_addr_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_IGNORE
    } state_t;

    localparam logic SDA_ACK  = 1'b0;
    localparam logic SDA_NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_cond_det.sv
// Synchronizes SCL/SDA into clk, detects SCL edges and START/STOP conditions.
// Define I2C_SLV_GLITCH_FILTER_EN to add a 3-sample majority filter per line.
module i2c_bus_cond_det (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_c,
    output logic scl_rise_c,
    output logic scl_fall_c,
    output logic start_c,
    output logic stop_c
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_f;
    logic       sda_f;
    logic       scl_q;
    logic       sda_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
        end
    end

`ifdef I2C_SLV_GLITCH_FILTER_EN
    logic [1:0] scl_hist;
    logic [1:0] sda_hist;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
        end
    end

    // A value must be seen on two of three consecutive samples to pass.
    assign scl_f = maj3(scl_sync[1], scl_hist[0], scl_hist[1]);
    assign sda_f = maj3(sda_sync[1], sda_hist[0], sda_hist[1]);
`else
    assign scl_f = scl_sync[1];
    assign sda_f = sda_sync[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    assign sda_c      = sda_f;
    assign scl_rise_c = scl_f & ~scl_q;
    assign scl_fall_c = ~scl_f & scl_q;
    assign start_c    = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_c     = scl_f & scl_q & ~sda_q & sda_f;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C slave exposing a byte register file with an auto-incrementing pointer.
// Define I2C_SLV_GLITCH_FILTER_EN to enable majority filtering on SCL/SDA.
module i2c_slave_responder
    import i2c_slave_pkg::*;
#(
    parameter i2c_addr_t   SLV_ADDR  = 7'h33,
    parameter int unsigned MEM_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       busy,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data
);

    localparam int unsigned PW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    state_t              state;
    logic [2:0]          bit_cnt;
    logic [BYTE_W-1:0]   shreg;
    logic [PW-1:0]       ptr;
    logic                rw;
    logic                ack_ph;
    logic                mack;
    logic [BYTE_W-1:0]   mem [MEM_DEPTH];

    logic                sda_c;
    logic                scl_rise_c;
    logic                scl_fall_c;
    logic                start_c;
    logic                stop_c;
    logic [BYTE_W-1:0]   byte_c;
    logic                byte_done_c;
    logic                mem_we_c;

    i2c_bus_cond_det u_det (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_c      (sda_c),
        .scl_rise_c (scl_rise_c),
        .scl_fall_c (scl_fall_c),
        .start_c    (start_c),
        .stop_c     (stop_c)
    );

    assign byte_c      = {shreg[6:0], sda_c};
    assign byte_done_c = scl_rise_c && (bit_cnt == 3'd7);
    assign mem_we_c    = (state == ST_WR_BYTE) && byte_done_c && !start_c && !stop_c;

    // Register file is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (mem_we_c) mem[ptr] <= byte_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            ptr      <= '0;
            rw       <= 1'b0;
            ack_ph   <= 1'b0;
            mack     <= SDA_NACK;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_valid <= 1'b0;
            // Bus conditions override everything, STOP first; partial bytes are dropped.
            if (stop_c) begin
                state   <= ST_IDLE;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
                bit_cnt <= '0;
            end else if (start_c) begin
                state   <= ST_ADDR;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
                bit_cnt <= '0;
            end else begin
                if (scl_rise_c) bit_cnt <= 3'(bit_cnt + 3'd1);
                case (state)
                    ST_IDLE, ST_IGNORE: sda_oe <= 1'b0;
                    ST_ADDR: begin
                        if (scl_rise_c) shreg <= byte_c;
                        if (byte_done_c) begin
                            if (byte_c[7:1] == SLV_ADDR) begin
                                state  <= ST_ADDR_ACK;
                                busy   <= 1'b1;
                                rw     <= byte_c[0];
                                ack_ph <= 1'b0;
                            end else begin
                                state  <= ST_IGNORE;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall_c && !ack_ph) begin
                            sda_oe <= 1'b1;
                            ack_ph <= 1'b1;
                        end else if (scl_fall_c) begin
                            bit_cnt <= '0;
                            if (rw) begin
                                state  <= ST_RD_BYTE;
                                shreg  <= {mem[ptr][6:0], 1'b0};
                                sda_oe <= ~mem[ptr][7];
                            end else begin
                                state  <= ST_PTR;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    ST_PTR: begin
                        if (scl_rise_c) shreg <= byte_c;
                        if (byte_done_c) begin
                            ptr    <= PW'(byte_c);
                            state  <= ST_WR_ACK;
                            ack_ph <= 1'b0;
                        end
                    end
                    ST_WR_BYTE: begin
                        if (scl_rise_c) shreg <= byte_c;
                        if (byte_done_c) begin
                            wr_valid <= 1'b1;
                            wr_addr  <= 8'(ptr);
                            wr_data  <= byte_c;
                            ptr      <= PW'(ptr + 1'b1);
                            state    <= ST_WR_ACK;
                            ack_ph   <= 1'b0;
                        end
                    end
                    ST_WR_ACK: begin
                        if (scl_fall_c && !ack_ph) begin
                            sda_oe <= 1'b1;
                            ack_ph <= 1'b1;
                        end else if (scl_fall_c) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= ST_WR_BYTE;
                        end
                    end
                    ST_RD_BYTE: begin
                        if (byte_done_c) begin
                            state  <= ST_RD_ACK;
                            ack_ph <= 1'b0;
                            ptr    <= PW'(ptr + 1'b1);
                        end else if (scl_fall_c) begin
                            sda_oe <= ~shreg[7];
                            shreg  <= {shreg[6:0], 1'b0};
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_fall_c && !ack_ph) begin
                            sda_oe <= 1'b0;
                            ack_ph <= 1'b1;
                        end else if (scl_rise_c && ack_ph) begin
                            mack <= sda_c;
                        end else if (scl_fall_c) begin
                            bit_cnt <= '0;
                            if (mack == SDA_ACK) begin
                                state  <= ST_RD_BYTE;
                                shreg  <= {mem[ptr][6:0], 1'b0};
                                sda_oe <= ~mem[ptr][7];
                            end else begin
                                state  <= ST_IGNORE;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench: bit-banged I2C master against the slave responder.
module tb_i2c_slave_responder;
    import i2c_slave_pkg::*;

    localparam int unsigned Q = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_m;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_oe;
    logic       busy;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;

    int checks   = 0;
    int failures = 0;

    int          wr_n     = 0;
    int          oe_cyc   = 0;
    int          busy_cyc = 0;
    logic [15:0] wr_log [64];

    always #5 clk = ~clk;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave_responder #(.SLV_ADDR(7'h33), .MEM_DEPTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (scl_m),
        .sda_i    (sda_bus),
        .sda_oe   (sda_oe),
        .busy     (busy),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    always @(negedge clk) begin
        if (wr_valid === 1'b1) begin
            if (wr_n < 64) wr_log[6'(wr_n)] <= {wr_addr, wr_data};
            wr_n <= wr_n + 1;
        end
        if (sda_oe === 1'b1) oe_cyc <= oe_cyc + 1;
        if (busy === 1'b1) busy_cyc <= busy_cyc + 1;
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic bus_bit(input logic b, output logic seen);
        sda_m = b;    wait_q();
        scl_m = 1'b1; wait_q();
        seen  = sda_bus;
        wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, s);
        acked = (s == 1'b0);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        bus_bit(nack, s);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL reset_wr_valid: got %b expected 0", wr_valid); end
        checks++; if (wr_addr !== 8'h00) begin failures++; $display("FAIL reset_wr_addr: got %h expected 00", wr_addr); end
        checks++; if (wr_data !== 8'h00) begin failures++; $display("FAIL reset_wr_data: got %h expected 00", wr_data); end
        checks++; if (dut.state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", dut.state, ST_IDLE); end
        rst_n = 1'b1;
        wait_q();
    endtask

    task automatic test_write();
        int   base;
        logic a;
        base = wr_n;
        bus_start();
        send_byte(8'h66, a);
        checks++; if (a !== 1'b1) begin failures++; $display("FAIL wr_addr_ack: got %b expected 1", a); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy: got %b expected 1", busy); end
        send_byte(8'h02, a);
        checks++; if (a !== 1'b1) begin failures++; $display("FAIL wr_ptr_ack: got %b expected 1", a); end
        send_byte(8'hA5, a);
        checks++; if (a !== 1'b1) begin failures++; $display("FAIL wr_data0_ack: got %b expected 1", a); end
        send_byte(8'h5A, a);
        checks++; if (a !== 1'b1) begin failures++; $display("FAIL wr_data1_ack: got %b expected 1", a); end
        bus_stop();
        wait_q();
        checks++; if (wr_n - base !== 2) begin failures++; $display("FAIL wr_count: got %0d expected 2", wr_n - base); end
        checks++; if (wr_log[6'(base)] !== 16'h02A5) begin failures++; $display("FAIL wr_entry0: got %h expected 02a5", wr_log[6'(base)]); end
        checks++; if (wr_log[6'(base + 1)] !== 16'h035A) begin failures++; $display("FAIL wr_entry1: got %h expected 035a", wr_log[6'(base + 1)]); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy_after_stop: got %b expected 0", busy); end
    endtask

    task automatic test_read();
        int         base;
        logic       a;
        logic [7:0] d;
        base = wr_n;
        bus_start();
        send_byte(8'h66, a);
        send_byte(8'h02, a);
        checks++; if (a !== 1'b1) begin failures++; $display("FAIL rd_ptr_ack: got %b expected 1", a); end
        bus_start();
        send_byte(8'h67, a);
        checks++; if (a !== 1'b1) begin failures++; $display("FAIL rd_addr_ack: got %b expected 1", a); end
        read_byte(1'b0, d);
        checks++; if (d !== 8'hA5) begin failures++; $display("FAIL rd_byte0: got %h expected a5", d); end
        read_byte(1'b1, d);
        checks++; if (d !== 8'h5A) begin failures++; $display("FAIL rd_byte1: got %h expected 5a", d); end
        wait_q();
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL rd_release_after_nack: got %b expected 0", sda_oe); end
        bus_stop();
        wait_q();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rd_busy_after_stop: got %b expected 0", busy); end
        checks++; if (wr_n - base !== 0) begin failures++; $display("FAIL rd_no_writes: got %0d expected 0", wr_n - base); end
    endtask

    task automatic test_addr_nack();
        int   base, oe0, busy0;
        logic a;
        base = wr_n; oe0 = oe_cyc; busy0 = busy_cyc;
        bus_start();
        send_byte(8'h68, a);
        checks++; if (a !== 1'b0) begin failures++; $display("FAIL nack_addr: got ack=%b expected 0", a); end
        send_byte(8'h02, a);
        checks++; if (a !== 1'b0) begin failures++; $display("FAIL nack_data: got ack=%b expected 0", a); end
        bus_stop();
        wait_q();
        checks++; if (oe_cyc - oe0 !== 0) begin failures++; $display("FAIL nack_sda_oe_cycles: got %0d expected 0", oe_cyc - oe0); end
        checks++; if (busy_cyc - busy0 !== 0) begin failures++; $display("FAIL nack_busy_cycles: got %0d expected 0", busy_cyc - busy0); end
        checks++; if (wr_n - base !== 0) begin failures++; $display("FAIL nack_writes: got %0d expected 0", wr_n - base); end
    endtask

    task automatic test_wrap();
        int   base;
        logic a, all_ack;
        base = wr_n;
        all_ack = 1'b1;
        bus_start();
        send_byte(8'h66, a); all_ack &= a;
        send_byte(8'h0F, a); all_ack &= a;
        send_byte(8'h11, a); all_ack &= a;
        send_byte(8'h22, a); all_ack &= a;
        bus_stop();
        wait_q();
        checks++; if (all_ack !== 1'b1) begin failures++; $display("FAIL wrap_acks: got %b expected 1", all_ack); end
        checks++; if (wr_n - base !== 2) begin failures++; $display("FAIL wrap_count: got %0d expected 2", wr_n - base); end
        checks++; if (wr_log[6'(base)] !== 16'h0F11) begin failures++; $display("FAIL wrap_entry0: got %h expected 0f11", wr_log[6'(base)]); end
        checks++; if (wr_log[6'(base + 1)] !== 16'h0022) begin failures++; $display("FAIL wrap_entry1: got %h expected 0022", wr_log[6'(base + 1)]); end
    endtask

    task automatic test_abort();
        int   base;
        logic a, s;
        base = wr_n;
        bus_start();
        send_byte(8'h66, a);
        send_byte(8'h05, a);
        bus_bit(1'b1, s); bus_bit(1'b0, s); bus_bit(1'b1, s); bus_bit(1'b1, s);
        bus_stop();
        wait_q();
        checks++; if (wr_n - base !== 0) begin failures++; $display("FAIL abort_no_write: got %0d expected 0", wr_n - base); end
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL abort_sda_oe: got %b expected 0", sda_oe); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (dut.state !== ST_IDLE) begin failures++; $display("FAIL abort_state: got %0d expected %0d", dut.state, ST_IDLE); end
        bus_start();
        send_byte(8'h66, a);
        checks++; if (a !== 1'b1) begin failures++; $display("FAIL abort_next_addr_ack: got %b expected 1", a); end
        send_byte(8'h05, a);
        send_byte(8'h77, a);
        checks++; if (a !== 1'b1) begin failures++; $display("FAIL abort_next_data_ack: got %b expected 1", a); end
        bus_stop();
        wait_q();
        checks++; if (wr_n - base !== 1) begin failures++; $display("FAIL abort_next_count: got %0d expected 1", wr_n - base); end
        checks++; if (wr_log[6'(base)] !== 16'h0577) begin failures++; $display("FAIL abort_next_entry: got %h expected 0577", wr_log[6'(base)]); end
    endtask

    task automatic test_reset_mid_read();
        logic a, s;
        bus_start();
        send_byte(8'h66, a);
        send_byte(8'h00, a);
        send_byte(8'h00, a);
        bus_stop();
        bus_start();
        send_byte(8'h66, a);
        send_byte(8'h00, a);
        bus_start();
        send_byte(8'h67, a);
        bus_bit(1'b1, s); bus_bit(1'b1, s); bus_bit(1'b1, s);
        checks++; if (sda_oe !== 1'b1) begin failures++; $display("FAIL rst_mid_driving: got %b expected 1", sda_oe); end
        rst_n = 1'b0;
        #1;
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL rst_mid_sda_oe: got %b expected 0", sda_oe); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        checks++; if (dut.state !== ST_IDLE) begin failures++; $display("FAIL rst_mid_state: got %0d expected %0d", dut.state, ST_IDLE); end
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        rst_n = 1'b1; wait_q();
        scl_m = 1'b0; wait_q();
        send_byte(8'h66, a);
        checks++; if (a !== 1'b0) begin failures++; $display("FAIL rst_needs_start: got ack=%b expected 0", a); end
        bus_stop();
        bus_start();
        send_byte(8'h66, a);
        checks++; if (a !== 1'b1) begin failures++; $display("FAIL rst_then_start_ack: got %b expected 1", a); end
        bus_stop();
        wait_q();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_wrap();
        test_abort();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
